// File: rtl/cache_l2_nway.sv
// N-way set-associative, write-back, write-allocate L2 cache with controller FSM,
// tree pseudo-LRU replacement and hit/miss counters; 256-bit lines on both sides.
module cache_l2_nway #(
    parameter int s_offset = 5,
    parameter int s_index = 3,
    parameter int num_ways = 4,
    localparam int s_tag = 32 - s_offset - s_index,
    localparam int num_sets = 2 ** s_index,
    localparam int s_way = $clog2(num_ways)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [31:0]  mem_address,
    input  logic [255:0] mem_wdata,
    output logic [255:0] mem_rdata,
    output logic         mem_resp,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [31:0]  pmem_address,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp,
    output logic [31:0]  perf_hits,
    output logic [31:0]  perf_misses
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CHECK     = 2'd1,
        WRITEBACK = 2'd2,
        FILL      = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [num_ways-1:0] r_valid [num_sets];
    logic [num_ways-1:0] r_dirty [num_sets];
    logic [num_ways-2:0] r_plru  [num_sets];
    logic [s_tag-1:0]    r_tag   [num_sets][num_ways];
    logic [255:0]        r_data  [num_sets][num_ways];

    logic [s_way-1:0]    r_victim;
    logic                r_refill;
    logic [31:0]         r_hits;
    logic [31:0]         r_misses;

    logic [s_tag-1:0]    w_tag;
    logic [s_index-1:0]  w_set;
    logic [num_ways-1:0] w_hit_vec;
    logic                w_hit;
    logic [s_way-1:0]    w_hit_way;
    logic [s_way-1:0]    w_inv_way;
    logic                w_any_inv;
    logic [s_way-1:0]    w_victim;
    logic                w_check_hit;
    logic                w_unused;

    // Mark every tree node on the path to 'way' so that it points away from 'way'.
    function automatic logic [num_ways-2:0] plru_touch(input logic [num_ways-2:0] bits,
                                                       input logic [s_way-1:0] way);
        logic [num_ways-2:0] nb;
        int node;
        nb   = bits;
        node = 0;
        for (int lvl = 0; lvl < s_way; lvl++) begin
            nb[node] = ~way[s_way-1-lvl];
            node     = 2 * node + 1 + int'(way[s_way-1-lvl]);
        end
        return nb;
    endfunction

    // Walk the tree from the root: bit 0 selects the lower half, 1 the upper half.
    function automatic logic [s_way-1:0] plru_victim(input logic [num_ways-2:0] bits);
        logic [s_way-1:0] v;
        int node;
        v    = '0;
        node = 0;
        for (int lvl = 0; lvl < s_way; lvl++) begin
            v[s_way-1-lvl] = bits[node];
            node           = 2 * node + 1 + int'(bits[node]);
        end
        return v;
    endfunction

    assign w_tag    = mem_address[31:s_offset+s_index];
    assign w_set    = mem_address[s_offset+s_index-1:s_offset];
    assign w_unused = ^mem_address[s_offset-1:0];

    // Per-way tag match for the addressed set.
    always_comb begin
        w_hit_vec = '0;
        for (int w = 0; w < num_ways; w++) begin
            w_hit_vec[w] = r_valid[w_set][w] & (r_tag[w_set][w] == w_tag);
        end
    end

    // Encode the hit way; at most one way can match, so OR-ing indices is exact.
    always_comb begin
        w_hit_way = '0;
        for (int w = 0; w < num_ways; w++) begin
            w_hit_way = w_hit_way | (w_hit_vec[w] ? s_way'(w) : '0);
        end
    end

    // Lowest-index invalid way of the addressed set.
    always_comb begin
        w_inv_way = '0;
        for (int w = num_ways - 1; w >= 0; w--) begin
            w_inv_way = r_valid[w_set][w] ? w_inv_way : s_way'(w);
        end
    end

    assign w_hit       = |w_hit_vec;
    assign w_any_inv   = ~&r_valid[w_set];
    assign w_victim    = w_any_inv ? w_inv_way : plru_victim(r_plru[w_set]);
    assign w_check_hit = (r_state == CHECK) & w_hit;
    assign perf_hits   = r_hits;
    assign perf_misses = r_misses;

    // Controller next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (mem_read || mem_write) begin
                    w_state_nxt = CHECK;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            CHECK: begin
                if (w_hit) begin
                    w_state_nxt = IDLE;
                end else if (r_dirty[w_set][w_victim]) begin
                    w_state_nxt = WRITEBACK;
                end else begin
                    w_state_nxt = FILL;
                end
            end
            WRITEBACK: begin
                if (pmem_resp) begin
                    w_state_nxt = FILL;
                end else begin
                    w_state_nxt = WRITEBACK;
                end
            end
            FILL: begin
                if (pmem_resp) begin
                    w_state_nxt = CHECK;
                end else begin
                    w_state_nxt = FILL;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Interface outputs decoded from state so they drop together with an async reset.
    always_comb begin
        mem_resp     = w_check_hit;
        pmem_read    = (r_state == FILL);
        pmem_write   = (r_state == WRITEBACK);
        mem_rdata    = '0;
        pmem_address = '0;
        pmem_wdata   = '0;
        if (w_check_hit) begin
            mem_rdata = r_data[w_set][w_hit_way];
        end else begin
            mem_rdata = '0;
        end
        case (r_state)
            WRITEBACK: begin
                pmem_address = {r_tag[w_set][r_victim], w_set, {s_offset{1'b0}}};
                pmem_wdata   = r_data[w_set][r_victim];
            end
            FILL: begin
                pmem_address = {w_tag, w_set, {s_offset{1'b0}}};
                pmem_wdata   = '0;
            end
            default: begin
                pmem_address = '0;
                pmem_wdata   = '0;
            end
        endcase
    end

    // State register, line status bits, replacement state and performance counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_victim <= '0;
            r_refill <= 1'b0;
            r_hits   <= 32'd0;
            r_misses <= 32'd0;
            for (int s = 0; s < num_sets; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
                r_plru[s]  <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: r_refill <= 1'b0;
                CHECK: begin
                    if (w_hit) begin
                        r_plru[w_set] <= plru_touch(r_plru[w_set], w_hit_way);
                        if (mem_write) begin
                            r_dirty[w_set][w_hit_way] <= 1'b1;
                        end
                        if (!r_refill) begin
                            r_hits <= r_hits + 32'd1;
                        end
                    end else begin
                        r_victim <= w_victim;
                        if (!r_refill) begin
                            r_misses <= r_misses + 32'd1;
                        end
                    end
                end
                WRITEBACK: begin
                    if (pmem_resp) begin
                        r_dirty[w_set][r_victim] <= 1'b0;
                    end
                end
                FILL: begin
                    if (pmem_resp) begin
                        r_valid[w_set][r_victim] <= 1'b1;
                        r_dirty[w_set][r_victim] <= 1'b0;
                        r_refill                 <= 1'b1;
                    end
                end
                default: r_refill <= 1'b0;
            endcase
        end
    end

    // Tag and data storage; contents are qualified by the valid bits, so no reset.
    always_ff @(posedge clk) begin
        if (w_check_hit && mem_write) begin
            r_data[w_set][w_hit_way] <= mem_wdata;
        end else if ((r_state == FILL) && pmem_resp) begin
            r_data[w_set][r_victim] <= pmem_rdata;
            r_tag[w_set][r_victim]  <= w_tag;
        end
    end

endmodule

// File: tb/tb_cache_l2_nway.sv
// Self-checking bench for cache_l2_nway: scoreboard of expected read data, a
// reference view of memory, and a configurable-latency physical memory responder.
module tb_cache_l2_nway;

    logic         clk;
    logic         rst_n;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_address;
    logic [255:0] mem_wdata;
    logic [255:0] mem_rdata;
    logic         mem_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic [31:0]  perf_hits;
    logic [31:0]  perf_misses;

    cache_l2_nway dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_address  (mem_address),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_resp     (mem_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .perf_hits    (perf_hits),
        .perf_misses  (perf_misses)
    );

    typedef struct {
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] data;
    } pmem_txn_t;

    typedef struct {
        bit           rd;
        logic [255:0] data;
    } sb_item_t;

    pmem_txn_t    pmem_log[$];
    sb_item_t     sb_q[$];
    logic [255:0] pmem_store [logic [31:0]];
    logic [255:0] ref_mem    [logic [31:0]];

    int n_total = 0;
    int n_bad = 0;
    int resp_delay = 1;
    bit inject_late = 1'b0;
    int exp_hits = 0;
    int exp_misses = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [255:0] line_pat(input logic [31:0] a);
        return {8{a ^ 32'hC0DE_0000}};
    endfunction

    function automatic logic [255:0] store_get(input logic [31:0] a);
        if (pmem_store.exists(a)) return pmem_store[a];
        return line_pat(a);
    endfunction

    function automatic logic [255:0] ref_get(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return store_get(a);
    endfunction

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Physical memory: answers after resp_delay active cycles; can inject a stray response.
    initial begin : pmem_responder
        int cnt;
        cnt        = 0;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            pmem_resp = 1'b0;
            if (inject_late) begin
                inject_late = 1'b0;
                pmem_resp   = 1'b1;
                pmem_rdata  = {8{$urandom()}};
                cnt         = 0;
            end else if (!rst_n || !(pmem_read || pmem_write)) begin
                cnt = 0;
            end else begin
                cnt++;
                if (cnt >= resp_delay) begin
                    cnt       = 0;
                    pmem_resp = 1'b1;
                    if (pmem_write) begin
                        pmem_store[pmem_address] = pmem_wdata;
                        pmem_log.push_back('{1'b1, pmem_address, pmem_wdata});
                    end else begin
                        pmem_rdata = store_get(pmem_address);
                        pmem_log.push_back('{1'b0, pmem_address, pmem_rdata});
                    end
                end
            end
        end
    end

    // Scoreboard: every completion must match the oldest outstanding request.
    always @(negedge clk) begin
        if (mem_resp) begin
            sb_item_t it;
            chk("sb_pending", 256'(sb_q.size() != 0), 256'd1);
            if (sb_q.size() != 0) begin
                it = sb_q.pop_front();
                if (it.rd) chk($sformatf("rdata@%0h", mem_address), mem_rdata, it.data);
            end
        end
    end

    // kind: 0 = hit, 1 = clean miss, 2 = dirty miss evicting wb_addr.
    task automatic do_req(input bit wr, input logic [31:0] addr, input logic [255:0] wd,
                          input int kind, input logic [31:0] wb_addr);
        int lat;
        int n_pr;
        int n_pw;
        int exp_lat;
        bit got;
        logic [255:0] wb_exp;
        wb_exp = ref_get(wb_addr);
        pmem_log.delete();
        @(negedge clk);
        if (wr) begin
            sb_q.push_back('{1'b0, wd});
            ref_mem[addr] = wd;
        end else begin
            sb_q.push_back('{1'b1, ref_get(addr)});
        end
        mem_read    = !wr;
        mem_write   = wr;
        mem_address = addr;
        mem_wdata   = wd;
        lat  = 1;
        n_pr = 0;
        n_pw = 0;
        got  = 1'b0;
        while (!got && lat < 300) begin
            @(negedge clk);
            lat++;
            if (pmem_read) n_pr++;
            if (pmem_write) n_pw++;
            got = mem_resp;
        end
        chk($sformatf("resp@%0h", addr), 256'(got), 256'd1);
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        if (kind == 0) exp_hits++;
        else exp_misses++;
        exp_lat = (kind == 0) ? 2 : ((kind == 1) ? 3 + resp_delay : 3 + 2 * resp_delay);
        chk($sformatf("latency@%0h", addr), 256'(lat), 256'(exp_lat));
        chk($sformatf("pread_cycles@%0h", addr), 256'(n_pr), 256'((kind == 0) ? 0 : resp_delay));
        chk($sformatf("pwrite_cycles@%0h", addr), 256'(n_pw), 256'((kind == 2) ? resp_delay : 0));
        chk($sformatf("pmem_txns@%0h", addr), 256'(pmem_log.size()), 256'(kind));
        chk($sformatf("perf_hits@%0h", addr), 256'(perf_hits), 256'(exp_hits));
        chk($sformatf("perf_misses@%0h", addr), 256'(perf_misses), 256'(exp_misses));
        if (kind == 2 && pmem_log.size() == 2) begin
            chk($sformatf("wb_is_write@%0h", addr), 256'(pmem_log[0].wr), 256'd1);
            chk($sformatf("wb_addr@%0h", addr), 256'(pmem_log[0].addr), 256'(wb_addr));
            chk($sformatf("wb_data@%0h", addr), pmem_log[0].data, wb_exp);
            chk($sformatf("fill_addr@%0h", addr), 256'(pmem_log[1].addr), 256'(addr));
        end else if (kind == 1 && pmem_log.size() == 1) begin
            chk($sformatf("fill_is_read@%0h", addr), 256'(pmem_log[0].wr), 256'd0);
            chk($sformatf("fill_addr@%0h", addr), 256'(pmem_log[0].addr), 256'(addr));
        end
    endtask

    initial begin : main
        int k;
        rst_n       = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = 32'd0;
        mem_wdata   = '0;
        repeat (3) @(negedge clk);
        chk("rst_mem_resp", 256'(mem_resp), 256'd0);
        chk("rst_pmem_read", 256'(pmem_read), 256'd0);
        chk("rst_pmem_write", 256'(pmem_write), 256'd0);
        chk("rst_pmem_address", 256'(pmem_address), 256'd0);
        chk("rst_mem_rdata", mem_rdata, 256'd0);
        chk("rst_pmem_wdata", pmem_wdata, 256'd0);
        chk("rst_perf_hits", 256'(perf_hits), 256'd0);
        chk("rst_perf_misses", 256'(perf_misses), 256'd0);
        rst_n = 1'b1;

        // Cold miss then repeat hit.
        do_req(1'b0, 32'h040, '0, 1, 32'h0);
        do_req(1'b0, 32'h040, '0, 0, 32'h0);

        // Fill set 2, refresh way 0, then PLRU picks way 2 for 0x440.
        do_req(1'b0, 32'h140, '0, 1, 32'h0);
        do_req(1'b0, 32'h240, '0, 1, 32'h0);
        do_req(1'b0, 32'h340, '0, 1, 32'h0);
        do_req(1'b0, 32'h040, '0, 0, 32'h0);
        do_req(1'b0, 32'h440, '0, 1, 32'h0);
        do_req(1'b0, 32'h240, '0, 1, 32'h0);
        do_req(1'b0, 32'h040, '0, 0, 32'h0);
        do_req(1'b0, 32'h340, '0, 0, 32'h0);

        // Write-allocate into set 3, then dirty evictions.
        for (int i = 0; i < 4; i++) begin
            do_req(1'b1, 32'h060 + 32'(i) * 32'h100, {8{32'hB000_0000 + 32'(i)}}, 1, 32'h0);
        end
        do_req(1'b0, 32'h460, '0, 2, 32'h060);
        do_req(1'b0, 32'h160, '0, 0, 32'h0);
        do_req(1'b1, 32'h160, {8{32'hB9B9_0001}}, 0, 32'h0);
        do_req(1'b0, 32'h160, '0, 0, 32'h0);
        do_req(1'b0, 32'h060, '0, 2, 32'h260);

        // Slow memory: fill held for many cycles.
        resp_delay = 11;
        do_req(1'b0, 32'h080, '0, 1, 32'h0);
        resp_delay = 1;

        // Reset in the middle of a fill.
        resp_delay = 100;
        @(negedge clk);
        mem_read    = 1'b1;
        mem_address = 32'h0A0;
        k = 0;
        while (!pmem_read && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("midfill_pmem_read", 256'(pmem_read), 256'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midfill_rst_pmem_read", 256'(pmem_read), 256'd0);
        chk("midfill_rst_pmem_address", 256'(pmem_address), 256'd0);
        chk("midfill_rst_perf_hits", 256'(perf_hits), 256'd0);
        chk("midfill_rst_perf_misses", 256'(perf_misses), 256'd0);
        mem_read    = 1'b0;
        mem_address = 32'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ref_mem.delete();
        exp_hits   = 0;
        exp_misses = 0;
        resp_delay = 1;
        @(negedge clk);
        inject_late = 1'b1;
        repeat (2) @(negedge clk);
        chk("late_resp_pmem_read", 256'(pmem_read), 256'd0);
        chk("late_resp_pmem_write", 256'(pmem_write), 256'd0);
        chk("late_resp_mem_resp", 256'(mem_resp), 256'd0);
        chk("late_resp_perf_misses", 256'(perf_misses), 256'd0);
        do_req(1'b0, 32'h040, '0, 1, 32'h0);

        repeat (2) @(negedge clk);
        chk("sb_drained", 256'(sb_q.size()), 256'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/cache_l2_nway.md
# cache_l2_nway

Parametrised N-way set-associative, write-back, write-allocate L2 cache with an integrated controller FSM, tree pseudo-LRU replacement and hit/miss performance counters. It sits between the L1 caches (256-bit line interface) and physical memory. It is the successor to the fixed 2-way L2 datapath. Tag, valid, dirty, PLRU and data storage are internal flop arrays.

## Interface
- s_offset, 5, line offset bits (line = 2**s_offset bytes; fixed 256-bit line requires 5)
- s_index, 3, set index bits; num_sets = 2**s_index
- num_ways, 4, associativity; power of two, ≥2
- s_tag, 32-s_offset-s_index, derived tag width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- mem_read  in  1  upstream line read request, held until mem_resp
- mem_write  in  1  upstream line write request, held until mem_resp
- mem_address  in  32  request address, held until mem_resp
- mem_wdata  in  256  write line
- mem_rdata  out  256  read line, valid when mem_resp
- mem_resp  out  1  one-cycle completion pulse
- pmem_read  out  1  memory line read, held until pmem_resp
- pmem_write  out  1  memory line write, held until pmem_resp
- pmem_address  out  32  line-aligned memory address (low s_offset bits 0)
- pmem_wdata  out  256  writeback line
- pmem_rdata  in  256  fill line, valid with pmem_resp
- pmem_resp  in  1  memory completion pulse
- perf_hits  out  32  count of CHECK cycles that hit on first lookup
- perf_misses  out  32  count of requests that missed

## Operation
- Address split: tag = [31:s_offset+s_index], set = [s_offset+s_index-1:s_offset].
- FSM states: IDLE, CHECK, WRITEBACK, FILL.
- IDLE: mem_read|mem_write → CHECK. Both asserted: treated as write.
- CHECK: hit = any way valid with matching tag (at most one). Hit: mem_resp=1; read drives mem_rdata from hit way; write loads mem_wdata into hit way, sets dirty; PLRU updated for hit way; → IDLE. Miss: victim = lowest-index invalid way, else PLRU victim; victim dirty → WRITEBACK, else → FILL. perf_misses increments once per request (not on the post-fill re-check); perf_hits increments only on a hit that needed no fill.
- WRITEBACK: pmem_write=1, pmem_address={victim tag,set,0}, pmem_wdata=victim line; on pmem_resp clear victim dirty → FILL.
- FILL: pmem_read=1, pmem_address={tag,set,0}; on pmem_resp write pmem_rdata, tag, valid=1, dirty=0 into victim → CHECK (re-check hits; writes then merge).
- PLRU: num_ways-1 bits per set, binary tree, root at node 0. Bit 0 = victim in lower half, 1 = upper half. Access to way w sets every node on its path to point away from w. Victim: follow bits from root.
- Counters wrap at 2**32.

## Timing
- Reset (async, immediate): FSM IDLE; all valid, dirty, PLRU bits 0; perf counters 0; mem_resp, pmem_read, pmem_write 0; pmem_address, mem_rdata, pmem_wdata 0 while IDLE. Data array not reset.
- Hit: request sampled in IDLE at edge N → CHECK in cycle N+1 with mem_resp=1; latency 2 cycles.
- Clean miss: CHECK, FILL (≥1 cycle, until pmem_resp), CHECK with mem_resp.
- Dirty miss: CHECK, WRITEBACK, FILL, CHECK.
- pmem_read/pmem_write are decoded from state; never both high; deassert the cycle after pmem_resp.
- Requester drops the request the cycle after mem_resp; the FSM is back in IDLE then, so back-to-back requests cost one IDLE cycle each.
- Reset during WRITEBACK/FILL abandons the memory transaction; pmem_* drop immediately; a late pmem_resp in IDLE is ignored.

## Test plan
- Reset, read 0x0000_0040 → pmem_read at 0x40, reply line A; mem_resp with A two cycles after pmem_resp edge; perf_misses=1.
- Repeat read 0x40 → mem_resp in 2nd cycle, no pmem activity, perf_hits=1.
- Fill set 2 with reads 0x040,0x140,0x240,0x340 (ways 0-3), read 0x040, then read 0x440 → victim way 2, no writeback. Then 0x240 misses and 0x040 hits.
- Cold writes of lines B0..B3 to 0x060,0x160,0x260,0x360, then read 0x460 → pmem_write 0x060 with B0, then pmem_read 0x460; later read 0x160 returns B1 with no pmem access.
- Hold pmem_resp low 10 cycles during FILL → pmem_read stays high, mem_resp stays 0 throughout.
- Assert rst_n low mid-FILL → pmem_read low the same cycle; counters 0; a late pmem_resp is ignored; next read of 0x040 misses.
